// File: rtl/laser_sched.sv
// laser_sched: two-circle cover search over a buffered point image.
//
// A 4-bit grid image of NPTS points is loaded one point per cycle, then the
// engine alternately re-places circle 1 and circle 2. Each placement sweeps
// all 256 grid centers, one per cycle, and keeps the center that covers the
// most points together with the other circle's current center. Refinement
// passes repeat until a pass no longer improves the total or MAX_PASS is hit.
//
// state | meaning
// ------+---------------------------------------------------------------
// LOAD  | sample (X,Y) into buffer slot idx each cycle, idx 0..NPTS-1
// SCAN1 | sweep cand 0..255 as circle-1 center, circle 2 held fixed
// UPD1  | commit best circle-1 center
// SCAN2 | sweep cand 0..255 as circle-2 center, circle 1 held fixed
// UPD2  | commit best circle-2 center, decide on another pass or finish
// FIN   | DONE pulse, outputs final; clear results and return to LOAD

module laser_sched #(
   parameter int NPTS     = 40,
   parameter int MAX_PASS = 8,
   parameter int R2       = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] X,
   input  logic [3:0] Y,
   output logic [3:0] C1X,
   output logic [3:0] C1Y,
   output logic [3:0] C2X,
   output logic [3:0] C2Y,
   output logic       DONE
);

   localparam int IDX_W  = (NPTS > 1) ? $clog2(NPTS) : 1;
   localparam int PASS_W = $clog2(MAX_PASS + 1);

   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NPTS - 1);
   localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(MAX_PASS);
   localparam logic [PASS_W-1:0] PASS_ONE  = PASS_W'(1);
   localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

   // Largest squared distance on the grid is 2*15^2 = 450, so a 10-bit
   // limit is exact; anything larger simply covers every point.
   localparam logic [9:0] R2_LIM = (R2 > 1023) ? 10'd1023 :
                                   (R2 < 0)    ? 10'd0    : 10'(R2);

   typedef enum logic [2:0] {
      LOAD  = 3'd0,
      SCAN1 = 3'd1,
      UPD1  = 3'd2,
      SCAN2 = 3'd3,
      UPD2  = 3'd4,
      FIN   = 3'd5
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [IDX_W-1:0]    idx;
   logic [7:0]          cand;
   logic [PASS_W-1:0]   pass;
   logic [5:0]          prev_total;
   logic [5:0]          best_score;
   logic [7:0]          best_idx;

   // Circle centers are kept packed as {y, x}, the same layout as cand,
   // so committing a winner is a plain copy of best_idx.
   logic [7:0]          c1;
   logic [7:0]          c2;

   // Point buffer, packed {y, x}. Not reset: contents are only meaningful
   // after a complete LOAD, which always rewrites every slot.
   logic [7:0]          pt_buf [NPTS];

   logic [7:0]          other_ctr;
   logic [5:0]          score;
   logic                load_last;
   logic                scan_last;
   logic                pass_stop;

   function automatic logic covers(input logic [7:0] ctr, input logic [7:0] pt);
      logic [3:0] dx;
      logic [3:0] dy;
      logic [7:0] dx2;
      logic [7:0] dy2;
      logic [9:0] d2;
      dx  = (ctr[3:0] >= pt[3:0]) ? (ctr[3:0] - pt[3:0]) : (pt[3:0] - ctr[3:0]);
      dy  = (ctr[7:4] >= pt[7:4]) ? (ctr[7:4] - pt[7:4]) : (pt[7:4] - ctr[7:4]);
      dx2 = {4'b0, dx} * {4'b0, dx};
      dy2 = {4'b0, dy} * {4'b0, dy};
      d2  = {2'b0, dx2} + {2'b0, dy2};
      return (d2 <= R2_LIM);
   endfunction

   assign load_last = (idx == IDX_LAST);
   assign scan_last = (cand == 8'hFF);
   assign pass_stop = (best_score <= prev_total) || (pass == PASS_LAST);

   // The circle not being re-placed in the current sweep stays fixed.
   assign other_ctr = (state == SCAN2) ? c1 : c2;

   // Coverage count for the current candidate, all points in one cycle.
   always_comb begin
      score = '0;
      for (int i = 0; i < NPTS; i++) begin
         if (covers(cand, pt_buf[i]) || covers(other_ctr, pt_buf[i])) begin
            score = score + 6'd1;
         end
      end
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (load_last) state_nxt = SCAN1;
         SCAN1:   if (scan_last) state_nxt = UPD1;
         UPD1:    state_nxt = SCAN2;
         SCAN2:   if (scan_last) state_nxt = UPD2;
         UPD2:    state_nxt = pass_stop ? FIN : SCAN1;
         FIN:     state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   // Outputs: DONE decoded from state, centers straight from their registers.
   always_comb begin
      DONE = (state == FIN);
      C1X  = c1[3:0];
      C1Y  = c1[7:4];
      C2X  = c2[3:0];
      C2Y  = c2[7:4];
   end

   // Point capture; RST blocks sampling so the first point lands on the
   // first edge after reset is released.
   always_ff @(posedge CLK) begin
      if (!RST && (state == LOAD)) begin
         pt_buf[idx] <= {Y, X};
      end
   end

   // Counters, best tracking, pass control and the committed centers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         idx        <= '0;
         cand       <= '0;
         pass       <= PASS_ONE;
         prev_total <= '0;
         best_score <= '0;
         best_idx   <= '0;
         c1         <= '0;
         c2         <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (load_last) begin
                  idx        <= '0;
                  cand       <= '0;
                  pass       <= PASS_ONE;
                  best_score <= '0;
                  best_idx   <= '0;
               end else begin
                  idx <= idx + IDX_ONE;
               end
            end
            SCAN1, SCAN2: begin
               // Strict compare: on ties the earlier (lower) candidate wins.
               if (score > best_score) begin
                  best_score <= score;
                  best_idx   <= cand;
               end
               cand <= cand + 8'd1;
            end
            UPD1: begin
               c1         <= best_idx;
               cand       <= '0;
               best_score <= '0;
               best_idx   <= '0;
            end
            UPD2: begin
               c2 <= best_idx;
               if (!pass_stop) begin
                  prev_total <= best_score;
                  pass       <= pass + PASS_ONE;
                  cand       <= '0;
                  best_score <= '0;
                  best_idx   <= '0;
               end
            end
            FIN: begin
               idx        <= '0;
               cand       <= '0;
               pass       <= PASS_ONE;
               prev_total <= '0;
               c1         <= '0;
               c2         <= '0;
            end
            default: begin
               idx  <= '0;
               cand <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_laser_sched.sv
// Self-checking bench for laser_sched: scenario tasks push expected results
// (centers and DONE cycle) into a scoreboard; a collector pops on DONE, and
// a per-cycle monitor watches DONE width and when the centers may change.

module tb_laser_sched;

   localparam int NPTS = 40;
   localparam int LAT  = NPTS + 514 * 2 + 1;   // DONE cycle for a 2-pass image

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [3:0] X   = 4'd0;
   logic [3:0] Y   = 4'd0;
   logic [3:0] C1X, C1Y, C2X, C2Y;
   logic       DONE;

   laser_sched #(.NPTS(NPTS), .MAX_PASS(8), .R2(16)) dut (
      .CLK  (CLK),
      .RST  (RST),
      .X    (X),
      .Y    (Y),
      .C1X  (C1X),
      .C1Y  (C1Y),
      .C2X  (C2X),
      .C2Y  (C2Y),
      .DONE (DONE)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] c1;       // {y, x}
      logic [7:0] c2;       // {y, x}
      int         done_cyc;
   } exp_t;

   exp_t sb_q[$];

   int   job_start  = 0;
   bit   job_active = 1'b0;
   bit   mon_en     = 1'b0;
   logic prev_done  = 1'b0;
   logic prev_rst   = 1'b1;
   logic [7:0] prev_c1 = 8'h00;
   logic [7:0] prev_c2 = 8'h00;

   // Image patterns, packed {y, x}.
   // 0: all (5,5)   1: 20x(2,2) + 20x(12,12)
   // 2: 20x(5,5) + 20x(3,4)   3: all (15,15)
   function automatic logic [7:0] pt(input int kind, input int i);
      case (kind)
         0:       return 8'h55;
         1:       return (i < 20) ? 8'h22 : 8'hCC;
         2:       return (i < 20) ? 8'h55 : 8'h43;
         default: return 8'hFF;
      endcase
   endfunction

   // Hand-derived final circle-1 centers, packed {y, x}; circle 2 ends at
   // (0,0) for every pattern here, and each needs exactly two passes.
   function automatic logic [7:0] exp_c1(input int kind);
      case (kind)
         0:       return 8'h15;   // (5,1): lowest cand within 4 of (5,5)
         1:       return 8'h8C;   // (12,8): C2=(0,0) already covers (2,2)
         2:       return 8'h15;   // (5,1): covers (5,5) and (3,4) together
         default: return 8'hBF;   // (15,11)
      endcase
   endfunction

   function automatic bit upd_slot(input int r, input int first);
      return (r >= first) && (((r - first) % 514) == 0);
   endfunction

   // Collector: pop on each DONE and compare against the scoreboard.
   always @(negedge CLK) begin
      if (DONE) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: cycle %0d got DONE=1, want no pulse", cyc);
         end else begin
            checks++;
            if (cyc !== sb_q[0].done_cyc) begin
               errors++;
               $display("FAIL done_cycle: got cycle %0d, want %0d", cyc, sb_q[0].done_cyc);
            end
            checks++;
            if ({C1Y, C1X} !== sb_q[0].c1) begin
               errors++;
               $display("FAIL c1_result: got (%0d,%0d), want (%0d,%0d)",
                        C1X, C1Y, sb_q[0].c1[3:0], sb_q[0].c1[7:4]);
            end
            checks++;
            if ({C2Y, C2X} !== sb_q[0].c2) begin
               errors++;
               $display("FAIL c2_result: got (%0d,%0d), want (%0d,%0d)",
                        C2X, C2Y, sb_q[0].c2[3:0], sb_q[0].c2[7:4]);
            end
            void'(sb_q.pop_front());
         end
      end
   end

   // Monitor: DONE never two cycles high; centers change only right after
   // UPD1 / UPD2 of the running image, or cleared after DONE or reset.
   always @(negedge CLK) begin
      if (mon_en) begin
         checks++;
         if (DONE && prev_done) begin
            errors++;
            $display("FAIL done_width: cycle %0d got DONE high 2 cycles, want 1", cyc);
         end
         checks++;
         if (({C1Y, C1X} !== prev_c1) && !(prev_rst || prev_done ||
             (job_active && upd_slot(cyc - job_start, NPTS + 257)))) begin
            errors++;
            $display("FAIL c1_change: cycle %0d got %0h from %0h, want no change",
                     cyc, {C1Y, C1X}, prev_c1);
         end
         checks++;
         if (({C2Y, C2X} !== prev_c2) && !(prev_rst || prev_done ||
             (job_active && upd_slot(cyc - job_start, NPTS + 514)))) begin
            errors++;
            $display("FAIL c2_change: cycle %0d got %0h from %0h, want no change",
                     cyc, {C2Y, C2X}, prev_c2);
         end
      end
      prev_done <= DONE;
      prev_rst  <= RST;
      prev_c1   <= {C1Y, C1X};
      prev_c2   <= {C2Y, C2X};
   end

   task automatic drive_junk();
      X = 4'($urandom_range(15));
      Y = 4'($urandom_range(15));
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         drive_junk();
         @(posedge CLK); #1;
      end
   endtask

   task automatic apply_reset();
      @(posedge CLK); #1;
      RST        = 1'b1;
      job_active = 1'b0;
      drive_junk();
      repeat (2) begin
         @(posedge CLK); #1;
      end
      RST = 1'b0;
   endtask

   // Called right after an edge with RST low; the first point goes out in
   // this cycle. Outputs must read zero throughout LOAD.
   task automatic load_image(input int kind, input bit push);
      exp_t       e;
      logic [7:0] p;
      job_start  = cyc;
      job_active = 1'b1;
      if (push) begin
         e.c1       = exp_c1(kind);
         e.c2       = 8'h00;
         e.done_cyc = cyc + LAT - 1;
         sb_q.push_back(e);
      end
      for (int i = 0; i < NPTS; i++) begin
         p = pt(kind, i);
         X = p[3:0];
         Y = p[7:4];
         checks++;
         if (({C2Y, C2X, C1Y, C1X} !== 16'h0000) || (DONE !== 1'b0)) begin
            errors++;
            $display("FAIL load_outputs: pt %0d got C=%0h DONE=%0b, want C=0 DONE=0",
                     i, {C2Y, C2X, C1Y, C1X}, DONE);
         end
         @(posedge CLK); #1;
      end
      drive_junk();
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0) && (n < 1300)) begin
         drive_junk();
         @(posedge CLK); #1;
         n++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL done_timeout: got %0d results pending, want 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) begin
         drive_junk();
         @(posedge CLK); #1;
      end
      checks++;
      if (DONE !== 1'b0) begin
         errors++;
         $display("FAIL reset_done: got %0b, want 0", DONE);
      end
      checks++;
      if ({C1Y, C1X} !== 8'h00) begin
         errors++;
         $display("FAIL reset_c1: got %0h, want 0", {C1Y, C1X});
      end
      checks++;
      if ({C2Y, C2X} !== 8'h00) begin
         errors++;
         $display("FAIL reset_c2: got %0h, want 0", {C2Y, C2X});
      end
      mon_en = 1'b1;
      RST    = 1'b0;
   endtask

   task automatic test_image(input int kind);
      apply_reset();
      load_image(kind, 1'b1);
      wait_drain();
   endtask

   task automatic test_abort();
      apply_reset();
      load_image(0, 1'b0);
      wait_cycles(360);   // into SCAN2 of pass 1
      checks++;
      if ({C1Y, C1X} !== 8'h15) begin
         errors++;
         $display("FAIL abort_pre_c1: got %0h, want 15", {C1Y, C1X});
      end
      RST        = 1'b1;
      job_active = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b0;
      checks++;
      if (({C2Y, C2X, C1Y, C1X} !== 16'h0000) || (DONE !== 1'b0)) begin
         errors++;
         $display("FAIL abort_outputs: got C=%0h DONE=%0b, want C=0 DONE=0",
                  {C2Y, C2X, C1Y, C1X}, DONE);
      end
      load_image(0, 1'b1);
      wait_drain();
   endtask

   task automatic test_back_to_back();
      apply_reset();
      load_image(0, 1'b1);
      wait_cycles(LAT - NPTS);   // now in the cycle after A's DONE
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_a_done: got %0d pending, want 0", sb_q.size());
      end
      load_image(1, 1'b1);
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_image(0);
      test_image(1);
      test_image(2);
      test_image(3);
      test_abort();
      test_back_to_back();
      wait_cycles(4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by time limit, want finish");
      $fatal(1, "watchdog");
   end

endmodule
